// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between two word producers, the write arbiter and the FIFO write port.
// The arbiter connects through the slave modport; the producer/FIFO side uses master.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req0;
    logic [DATA_WIDTH-1:0] data0;
    logic                  ack0;
    logic                  req1;
    logic [DATA_WIDTH-1:0] data1;
    logic                  ack1;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  gnt_id;
    logic                  stall;
    logic                  stall_clr;

    modport master (
        output req0, data0, req1, data1, fifo_full, stall_clr,
        input  ack0, ack1, fifo_wr, fifo_wdata, gnt_id, stall
    );

    modport slave (
        input  req0, data0, req1, data1, fifo_full, stall_clr,
        output ack0, ack1, fifo_wr, fifo_wdata, gnt_id, stall
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter serialising words from two requesters onto one FIFO write port,
// with an idle cycle after every write and a sticky stall flag for long full waits.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int STALL_LIMIT = 255,
    parameter int CNT_WIDTH   = 8
) (
    input logic              clk,
    input logic              reset_n,
    fifo_wr_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STALL_LIMIT);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  gnt_q, gnt_d;
    logic                  rr_q, rr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  stall_q, stall_d;
    logic [1:0]            cand;
    logic                  winner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wdata_q <= '0;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // A full FIFO removes both requesters from arbitration; the pointer only breaks ties.
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        cand    = bus.fifo_full ? 2'b00 : {bus.req1, bus.req0};
        winner  = (cand == 2'b11) ? rr_q : cand[1];

        case (state_q)
            IDLE: begin
                if (cand != 2'b00) begin
                    wdata_d = winner ? bus.data1 : bus.data0;
                    gnt_d   = winner;
                    rr_d    = ~winner;
                    state_d = WRITE;
                end
                if ((bus.req0 || bus.req1) && bus.fifo_full && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        if (cnt_d == LIMIT) begin
            stall_d = 1'b1;
        end
        if (bus.stall_clr) begin
            cnt_d   = '0;
            stall_d = 1'b0;
        end
    end

    assign bus.fifo_wr    = (state_q == WRITE);
    assign bus.ack0       = (state_q == WRITE) && !gnt_q;
    assign bus.ack1       = (state_q == WRITE) && gnt_q;
    assign bus.fifo_wdata = wdata_q;
    assign bus.gnt_id     = gnt_q;
    assign bus.stall      = stall_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected writes go into a queue as requests are raised
// and are matched against every fifo_wr strobe; a second instance uses a short stall limit.
module tb_fifo_wr_arbiter;
    logic clk;
    logic reset_n;

    typedef struct {
        logic        gnt;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    fifo_wr_arbiter_if #(.DATA_WIDTH(16)) bus ();
    fifo_wr_arbiter_if #(.DATA_WIDTH(16)) bus_s ();

    assign bus_s.req0      = bus.req0;
    assign bus_s.data0     = bus.data0;
    assign bus_s.req1      = bus.req1;
    assign bus_s.data1     = bus.data1;
    assign bus_s.fifo_full = bus.fifo_full;
    assign bus_s.stall_clr = bus.stall_clr;

    fifo_wr_arbiter #(
        .DATA_WIDTH (16),
        .STALL_LIMIT(255),
        .CNT_WIDTH  (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    fifo_wr_arbiter #(
        .DATA_WIDTH (16),
        .STALL_LIMIT(4),
        .CNT_WIDTH  (3)
    ) dut_s (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic gnt, input logic [15:0] data);
        exp_t e;
        e.gnt  = gnt;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.data0     = '0;
        bus.data1     = '0;
        bus.fifo_full = 1'b0;
        bus.stall_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Every write strobe must match the oldest expected word and the matching ack.
    always @(negedge clk) begin
        if (reset_n) begin
            check("ack_exclusive", {31'b0, bus.ack0 & bus.ack1}, 32'd0);
            check("ack_needs_wr", {31'b0, (bus.ack0 | bus.ack1) & ~bus.fifo_wr}, 32'd0);
            if (bus.fifo_wr) begin
                check("write_was_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_wdata", {16'b0, bus.fifo_wdata}, {16'b0, e.data});
                    check("sb_gnt_id", {31'b0, bus.gnt_id}, {31'b0, e.gnt});
                    check("sb_ack0", {31'b0, bus.ack0}, {31'b0, ~e.gnt});
                    check("sb_ack1", {31'b0, bus.ack1}, {31'b0, e.gnt});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.data0     = '0;
        bus.data1     = '0;
        bus.fifo_full = 1'b0;
        bus.stall_clr = 1'b0;
        #2;
        check("rst_fifo_wr", {31'b0, bus.fifo_wr}, 32'd0);
        check("rst_ack0", {31'b0, bus.ack0}, 32'd0);
        check("rst_ack1", {31'b0, bus.ack1}, 32'd0);
        check("rst_wdata", {16'b0, bus.fifo_wdata}, 32'd0);
        check("rst_gnt_id", {31'b0, bus.gnt_id}, 32'd0);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);

        $display("[TB] single write");
        do_reset();
        bus.req0  = 1'b1;
        bus.data0 = 16'hA55A;
        push_exp(1'b0, 16'hA55A);
        @(negedge clk);
        check("single_wr", {31'b0, bus.fifo_wr}, 32'd1);
        check("single_ack0", {31'b0, bus.ack0}, 32'd1);
        check("single_wdata", {16'b0, bus.fifo_wdata}, 32'h0000A55A);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("single_wr_end", {31'b0, bus.fifo_wr}, 32'd0);
        check("single_drained", exp_q.size(), 32'd0);

        $display("[TB] contention");
        do_reset();
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 16'h1111;
        bus.data1 = 16'h2222;
        push_exp(1'b0, 16'h1111);
        push_exp(1'b1, 16'h2222);
        push_exp(1'b0, 16'h1111);
        push_exp(1'b1, 16'h2222);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check("cont_wr", {31'b0, bus.fifo_wr}, {31'b0, i[0]});
            check("cont_ack0", {31'b0, bus.ack0}, {31'b0, (i == 1) || (i == 5)});
            check("cont_ack1", {31'b0, bus.ack1}, {31'b0, (i == 3) || (i == 7)});
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        check("cont_wr_end", {31'b0, bus.fifo_wr}, 32'd0);
        check("cont_drained", exp_q.size(), 32'd0);

        $display("[TB] full blocking");
        do_reset();
        bus.req1      = 1'b1;
        bus.data1     = 16'hBEEF;
        bus.fifo_full = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("full_no_wr", {31'b0, bus.fifo_wr}, 32'd0);
        end
        bus.fifo_full = 1'b0;
        push_exp(1'b1, 16'hBEEF);
        @(negedge clk);
        check("full_release_wr", {31'b0, bus.fifo_wr}, 32'd1);
        check("full_release_ack1", {31'b0, bus.ack1}, 32'd1);
        check("full_stall_255", {31'b0, bus.stall}, 32'd0);
        check("full_stall_4", {31'b0, bus_s.stall}, 32'd1);
        bus.req1 = 1'b0;
        @(negedge clk);
        check("full_wr_end", {31'b0, bus.fifo_wr}, 32'd0);
        check("full_drained", exp_q.size(), 32'd0);

        $display("[TB] stall flag");
        do_reset();
        bus.req0      = 1'b1;
        bus.data0     = 16'h5A5A;
        bus.fifo_full = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_before_limit", {31'b0, bus_s.stall}, 32'd0);
        @(negedge clk);
        check("stall_at_limit", {31'b0, bus_s.stall}, 32'd1);
        check("stall_255_clear", {31'b0, bus.stall}, 32'd0);
        bus.fifo_full = 1'b0;
        push_exp(1'b0, 16'h5A5A);
        @(negedge clk);
        check("stall_write", {31'b0, bus_s.fifo_wr}, 32'd1);
        check("stall_held_wr", {31'b0, bus_s.stall}, 32'd1);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("stall_held_after", {31'b0, bus_s.stall}, 32'd1);
        bus.stall_clr = 1'b1;
        @(negedge clk);
        check("stall_cleared", {31'b0, bus_s.stall}, 32'd0);
        bus.stall_clr = 1'b0;
        check("stall_drained", exp_q.size(), 32'd0);

        $display("[TB] async reset mid-write");
        do_reset();
        bus.req0  = 1'b1;
        bus.data0 = 16'hC0DE;
        @(posedge clk);
        #2;
        check("mid_wr_active", {31'b0, bus.fifo_wr}, 32'd1);
        check("mid_ack0_active", {31'b0, bus.ack0}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_wr_dropped", {31'b0, bus.fifo_wr}, 32'd0);
        check("mid_ack0_dropped", {31'b0, bus.ack0}, 32'd0);
        check("mid_wdata_cleared", {16'b0, bus.fifo_wdata}, 32'd0);
        bus.req1  = 1'b1;
        bus.data1 = 16'h0BEE;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        push_exp(1'b0, 16'hC0DE);
        push_exp(1'b1, 16'h0BEE);
        @(negedge clk);
        check("mid_rewrite_ack0", {31'b0, bus.ack0}, 32'd1);
        bus.req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_second_ack1", {31'b0, bus.ack1}, 32'd1);
        bus.req1 = 1'b0;
        @(negedge clk);
        check("mid_drained", exp_q.size(), 32'd0);

        $display("[TB] pointer fairness");
        do_reset();
        bus.req1  = 1'b1;
        bus.data1 = 16'h1234;
        push_exp(1'b1, 16'h1234);
        @(negedge clk);
        check("fair_first_ack1", {31'b0, bus.ack1}, 32'd1);
        bus.req1 = 1'b0;
        @(negedge clk);
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 16'hAAAA;
        bus.data1 = 16'hBBBB;
        push_exp(1'b0, 16'hAAAA);
        push_exp(1'b1, 16'hBBBB);
        @(negedge clk);
        check("fair_req0_wins", {31'b0, bus.gnt_id}, 32'd0);
        bus.req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("fair_then_req1", {31'b0, bus.gnt_id}, 32'd1);
        bus.req1 = 1'b0;
        @(negedge clk);
        check("fair_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Two-requester, round-robin write arbiter that shares a single write port of the double-slot FIFO controller.
- Each FIFO write consumes two address slots.
- Serialises 16-bit words from two producers into the FIFO through a req/ack handshake, using the FIFO's registered full flag.
- Flags a sticky stall when requesters wait on a full FIFO for too long.

Parameters:
DATA_WIDTH, 16, width of one requester word; one word equals one FIFO write (two slots)
STALL_LIMIT, 255, number of blocked cycles before stall is set; must be >= 1
CNT_WIDTH, 8, stall counter width; must satisfy 2**CNT_WIDTH > STALL_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req0  in  1  requester 0 has a word; held high with stable data0 until ack0
data0  in  DATA_WIDTH  requester 0 word
ack0  out  1  one-cycle pulse: data0 was written to FIFO
req1  in  1  requester 1 has a word; held high with stable data1 until ack1
data1  in  DATA_WIDTH  requester 1 word
ack1  out  1  one-cycle pulse: data1 was written to FIFO
fifo_full  in  1  registered full flag from FIFO controller
fifo_wr  out  1  FIFO write strobe, one cycle
fifo_wdata  out  DATA_WIDTH  word written, valid when fifo_wr=1
gnt_id  out  1  requester owning the current or last write
stall  out  1  sticky stall flag
stall_clr  in  1  one-cycle clear for stall and stall counter

Behaviour:
Clock and reset:
- Single clock domain. Reset is asynchronous and active-low.
- While reset_n=0: state=IDLE; fifo_wr=0, ack0=0, ack1=0; fifo_wdata=0, gnt_id=0; stall=0, stall counter=0; rr priority pointer=0 (requester 0 favoured).
- Outputs drop immediately on reset assertion, with no clock needed.
- Reset asserted during WRITE aborts the write: no ack is issued and the requester keeps its req.

State machine (2 states):
- IDLE (arbitration cycle):
  - cand = {req1, req0} when fifo_full=0, else none.
  - If one candidate: grant it. If both: grant the requester selected by the rr pointer.
  - On grant, at the clock edge: fifo_wdata <= winner data, gnt_id <= winner, rr pointer <= ~winner, state <= WRITE.
  - If no candidate: stay in IDLE.
- WRITE (decoded outputs, no arbitration):
  - fifo_wr=1. ack[gnt_id]=1, other ack=0.
  - Next state is always IDLE.
  - The idle gap lets fifo_full reflect this write before the next decision.
- fifo_wr, ack0 and ack1 are decoded from registered state, so they are glitch-free. At most one ack is high per cycle, and an ack is never high without fifo_wr.

Latency and throughput:
- req sampled in IDLE at cycle T → fifo_wr and ack in cycle T+1 → next arbitration in T+2.
- Peak rate is one word every 2 cycles.
- A requester holding req continuously must present its next word by the edge that ends the ack cycle.

Arbitration:
- The rr pointer toggles only on a grant.
- Both requesters held continuously → grants alternate 0,1,0,1 starting from the pointer value.
- A lone requester is granted every IDLE cycle when not full, regardless of the pointer.

Full handling:
- fifo_full=1 in IDLE → no grant; pending reqs wait and no data is lost.
- fifo_full is ignored in the WRITE state.

Stall counter:
- Increments in IDLE when (req0|req1) and fifo_full=1.
- Saturates at STALL_LIMIT.
- Resets to 0 in the WRITE state.
- stall <= 1 when the counter reaches STALL_LIMIT. stall stays set through later writes until stall_clr.
- stall_clr=1: counter <= 0 and stall <= 0. stall_clr wins over a simultaneous increment or set that cycle.

Requester rules:
- req dropped before ack: the requester is simply not considered; no error.
- data changed while req is high and unacked is a protocol violation; the sampled value is the one present in the granting IDLE cycle.

Test Plan:
- Reset then single write: req0=1, data0=16'hA55A, full=0 at cycle 0 → cycle 1: fifo_wr=1, fifo_wdata=16'hA55A, ack0=1, gnt_id=0; cycle 2: fifo_wr=0.
- Contention: req0 and req1 held high, data0=16'h1111, data1=16'h2222, full=0 → fifo_wr at cycles 1,3,5,7 with data 1111,2222,1111,2222; ack0 and ack1 alternate; never both high.
- Full blocking: req1=1, fifo_full=1 for 10 cycles then 0 → no fifo_wr during the full cycles; write of data1 exactly 1 cycle after fifo_full falls; stall=0.
- Stall flag: STALL_LIMIT=4, req0=1, full=1 held → stall rises after 4 blocked IDLE cycles and stays 1 after full drops and the write completes; stall_clr pulse → stall=0 next cycle.
- Async reset mid-write: assert reset_n=0 during the WRITE cycle, off-edge → fifo_wr and ack0 fall with no clock edge; after release with req0 still high, the word is rewritten, with requester 0 favoured.
- Pointer fairness: grant req1 alone, then raise req0 and req1 together → requester 0 wins the next grant.
